// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg
//   Shared definitions for the UART TX arbiter:
//   - state_t            : arbiter state encoding (IDLE / OWN)
//   - clog2              : ceiling log2, used to size counters and indices
//   - calc_bit_cycles    : clock cycles per bit from clock and baud rate
//   - calc_idle_cycles   : owner-idle cycles before the grant is released
//   The timing localparams themselves depend on the top-level parameters,
//   so the top module derives BIT_CYCLES / IDLE_CYCLES through these helpers.
package uart_tx_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(385) = 9.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int calc_bit_cycles(input int clk_freq, input int baudrate);
        return clk_freq / baudrate;
    endfunction

    function automatic int calc_idle_cycles(input int idle_bits, input int bit_cycles);
        return idle_bits * bit_cycles;
    endfunction

endpackage

// File: rtl/uart_tx_arb_sync.sv
// uart_tx_arb_sync
//   Per-source input conditioning: SYNC_STAGES-deep synchroniser that resets
//   to the idle (high) level, followed by a falling-edge detector.
//   Ports:
//     clk_i  - system clock
//     rst_i  - synchronous active-high reset (all flops go to 1)
//     line   - raw, possibly asynchronous UART TX line
//     s      - synchronised line level
//     fe     - high for one cycle when s goes 1 -> 0 (frame start candidate)
module uart_tx_arb_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line,
    output logic s,
    output logic fe
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '1;
            s_prev_q <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], line};
            s_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s  = sync_q[SYNC_STAGES-1];
    assign fe = s_prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Merges NUM_CH UART TX lines onto one registered TX pin.
//   MODE=1: a source is granted the pin on its start edge and keeps it until
//           its line has been high for IDLE_BITS bit periods; start edges from
//           other sources meanwhile are discarded and reported on drop_o.
//   MODE=0: legacy wired-AND of all synchronised lines.
//   Ports:
//     clk_i      - system clock
//     rst_i      - synchronous active-high reset
//     uart_tx_i  - per-source TX lines (idle high, may be asynchronous)
//     uart_tx_o  - merged TX line, registered (SYNC_STAGES+1 cycles latency)
//     active_o   - one-hot current owner, zero when idle
//     drop_o     - one-cycle pulse per source whose frame start was discarded
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CLK_FREQ    = 32000000,
    parameter int BAUDRATE    = 1000000,
    parameter int IDLE_BITS   = 12,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] uart_tx_i,
    output logic              uart_tx_o,
    output logic [NUM_CH-1:0] active_o,
    output logic [NUM_CH-1:0] drop_o
);

    localparam int BIT_CYCLES  = calc_bit_cycles(CLK_FREQ, BAUDRATE);
    localparam int IDLE_CYCLES = calc_idle_cycles(IDLE_BITS, BIT_CYCLES);
    localparam int CNT_W       = clog2(IDLE_CYCLES + 1);
    localparam int IDX_W       = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_REL = CNT_W'(IDLE_CYCLES - 1);

    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] fe;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        uart_tx_arb_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .line  (uart_tx_i[g]),
            .s     (s[g]),
            .fe    (fe[g])
        );
    end

    function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tx_d;
    logic [NUM_CH-1:0] active_d;
    logic [NUM_CH-1:0] drop_d;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic              owner_line;
    logic              release_hit;

    assign owner_line  = s[owner_q];
    // Owner has been high for IDLE_CYCLES consecutive cycles including this one.
    assign release_hit = owner_line && (cnt_q == CNT_REL);

    // Round-robin search starting just after the previous owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!win_found && fe[IDX_W'((int'(last_q) + k) % NUM_CH)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(last_q) + k) % NUM_CH);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (MODE != 0) begin
            case (state_q)
                IDLE:    if (win_found)   state_d = OWN;
                OWN:     if (release_hit) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs, counter and owner bookkeeping.
    always_comb begin
        tx_d     = 1'b1;
        active_d = '0;
        drop_d   = '0;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        if (MODE == 0) begin
            tx_d = &s;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (win_found) begin
                        // Winner's start bit goes out on the grant cycle itself.
                        tx_d     = s[win_idx];
                        active_d = onehot(win_idx);
                        drop_d   = fe & ~onehot(win_idx);
                        owner_d  = win_idx;
                        last_d   = win_idx;
                    end
                end
                OWN: begin
                    tx_d     = owner_line;
                    drop_d   = fe & ~onehot(owner_q);
                    active_d = release_hit ? '0 : onehot(owner_q);
                    if (!owner_line) begin
                        cnt_d = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            uart_tx_o <= 1'b1;
            active_o  <= '0;
            drop_o    <= '0;
            cnt_q     <= '0;
            owner_q   <= '0;
            last_q    <= IDX_W'(NUM_CH - 1);
        end else begin
            uart_tx_o <= tx_d;
            active_o  <= active_d;
            drop_o    <= drop_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
        end
    end

endmodule
